// File: rtl/frog_pkg.sv
// frog_pkg: shared types for the frog LFSR bank.
// FSM state encoding and lane step-mode constants.
package frog_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    TEST = 2'd2
  } state_e;

  localparam logic MODE_FIB = 1'b0;
  localparam logic MODE_GAL = 1'b1;

endpackage

// File: rtl/frog_lfsr_lane.sv
// frog_lfsr_lane: one LFSR lane with serial load,
// Fibonacci/Galois step, reseed and a zero flag.
module frog_lfsr_lane
  import frog_pkg::*;
#(
  parameter int unsigned      WIDTH  = 8,
  parameter logic [WIDTH-1:0] RESEED = WIDTH'(1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic shift_i,
  input  logic tap_i,
  input  logic seed_i,
  input  logic clr_taps_i,
  input  logic step_i,
  input  logic mode_i,
  input  logic reseed_i,
  output logic out_o,
  output logic zero_o
);

  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] taps_q, taps_d;
  logic             fb;

  assign fb     = ^(lfsr_q & taps_q);
  assign out_o  = lfsr_q[0];
  assign zero_o = (lfsr_q == '0);

  // A shift always wins; the top never steps a lane it is loading.
  always_comb begin
    lfsr_d = lfsr_q;
    taps_d = taps_q;
    if (shift_i) begin
      taps_d = {tap_i, taps_q[WIDTH-1:1]};
      lfsr_d = {seed_i, lfsr_q[WIDTH-1:1]};
    end else if (clr_taps_i) begin
      taps_d = '0;
    end else if (reseed_i) begin
      lfsr_d = RESEED;
    end else if (step_i) begin
      unique case (mode_i)
        MODE_FIB: lfsr_d = {fb, lfsr_q[WIDTH-1:1]};
        MODE_GAL: lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? taps_q : '0);
        default:  lfsr_d = lfsr_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= '0;
      taps_q <= '0;
    end else begin
      lfsr_q <= lfsr_d;
      taps_q <= taps_d;
    end
  end

endmodule

// File: rtl/frog_lfsr_bank.sv
// frog_lfsr_bank: NCH LFSR lanes behind one serial
// program/seed port, with lock detect and test flush.
module frog_lfsr_bank
  import frog_pkg::*;
#(
  parameter int unsigned      WIDTH       = 8,
  parameter int unsigned      NCH         = 4,
  parameter bit               AUTO_RESEED = 1'b1,
  parameter logic [WIDTH-1:0] RESEED      = WIDTH'(1),
  localparam int unsigned     SW = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load_i,
  input  logic [SW-1:0]  sel_i,
  input  logic           program_i,
  input  logic           seed_i,
  input  logic           test_i,
  input  logic           run_i,
  input  logic           galois_i,
  output logic [NCH-1:0] out_o,
  output logic [NCH-1:0] valid_o,
  output logic [NCH-1:0] lock_o,
  output logic           busy_o,
  output logic           test_done_o
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [SW-1:0]    cur_ch_q;
  logic [NCH-1:0]   valid_q, valid_d;
  logic [NCH-1:0]   lock_q, lock_d;
  logic             done_q;

  logic             start_ld, start_tst, ld_end, ld_full, last_tst;
  logic [SW-1:0]    ld_ch;
  logic [NCH-1:0]   shift, clr, owned, step_en, zero;

  assign start_ld  = load_i && (state_q != LOAD);
  assign ld_ch     = start_ld ? sel_i : cur_ch_q;
  assign start_tst = (state_q == IDLE) && test_i && !load_i;
  assign ld_end    = (state_q == LOAD) && !load_i;
  assign ld_full   = (cnt_q == CW'(WIDTH));
  assign last_tst  = (state_q == TEST) && !load_i
                   && (cnt_q == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (load_i)      state_d = LOAD;
        else if (test_i) state_d = TEST;
      end
      LOAD: if (!load_i) state_d = IDLE;
      TEST: begin
        if (load_i)        state_d = LOAD;
        else if (last_tst) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (state_q != IDLE);
    test_done_o = done_q;
    valid_o     = valid_q;
    lock_o      = lock_q;
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_lane
      assign shift[g] = (load_i && ld_ch == SW'(g))
                     || (state_q == TEST && !load_i
                         && cur_ch_q == SW'(g));
      assign clr[g]   = start_tst && (sel_i == SW'(g));
      // The lane owned by LOAD/TEST must not free-run.
      assign owned[g] = shift[g] || clr[g]
                     || (busy_o && cur_ch_q == SW'(g));
      assign step_en[g] = run_i && valid_q[g] && !owned[g];

      frog_lfsr_lane #(
        .WIDTH  (WIDTH),
        .RESEED (RESEED)
      ) u_lane (
        .clk        (clk),
        .rst_n      (rst_n),
        .shift_i    (shift[g]),
        .tap_i      (program_i && load_i),
        .seed_i     (seed_i && load_i),
        .clr_taps_i (clr[g]),
        .step_i     (step_en[g] && !zero[g]),
        .mode_i     (galois_i),
        .reseed_i   (step_en[g] && zero[g] && AUTO_RESEED),
        .out_o      (out_o[g]),
        .zero_o     (zero[g])
      );
    end
  endgenerate

  always_comb begin
    valid_d = valid_q;
    lock_d  = lock_q | (step_en & zero);
    for (int i = 0; i < NCH; i++) begin
      if (ld_end && cur_ch_q == SW'(i)) begin
        valid_d[i] = ld_full;
        if (ld_full) lock_d[i] = 1'b0;
      end else if (clr[i]) begin
        valid_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      cur_ch_q <= '0;
      valid_q  <= '0;
      lock_q   <= '0;
      done_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      lock_q  <= lock_d;
      done_q  <= last_tst;
      if (start_ld || start_tst) cur_ch_q <= sel_i;
      if (start_ld)                cnt_q <= CW'(1);
      else if (load_i && !ld_full) cnt_q <= cnt_q + 1'b1;
      else if (load_i)             cnt_q <= cnt_q;
      else if (state_q == TEST)    cnt_q <= cnt_q + 1'b1;
      else                         cnt_q <= '0;
    end
  end

endmodule

// File: tb/tb_frog_lfsr_bank.sv
// tb_frog_lfsr_bank: table-driven step checks with a
// scoreboard queue, plus flush, short-load and reset sequences.
module tb_frog_lfsr_bank;

  logic       clk, rst_n;
  logic       ld, prog, sd, tst, run, gal;
  logic [1:0] sel;
  logic [3:0] out, valid, lock;
  logic       busy, tdone;

  frog_lfsr_bank dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .load_i      (ld),
    .sel_i       (sel),
    .program_i   (prog),
    .seed_i      (sd),
    .test_i      (tst),
    .run_i       (run),
    .galois_i    (gal),
    .out_o       (out),
    .valid_o     (valid),
    .lock_o      (lock),
    .busy_o      (busy),
    .test_done_o (tdone)
  );

  logic [7:0] lf [4];
  logic [7:0] tp [4];
  assign lf[0] = dut.g_lane[0].u_lane.lfsr_q;
  assign lf[1] = dut.g_lane[1].u_lane.lfsr_q;
  assign lf[2] = dut.g_lane[2].u_lane.lfsr_q;
  assign lf[3] = dut.g_lane[3].u_lane.lfsr_q;
  assign tp[0] = dut.g_lane[0].u_lane.taps_q;
  assign tp[1] = dut.g_lane[1].u_lane.taps_q;
  assign tp[2] = dut.g_lane[2].u_lane.taps_q;
  assign tp[3] = dut.g_lane[3].u_lane.taps_q;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         lane;
    logic       gal;
    logic [7:0] exp_lf;
    logic       exp_out;
    logic       exp_lock;
  } vec_t;

  vec_t tbl [8];
  vec_t sbq [$];
  int   n_chk = 0;
  int   n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_lane(input int lane, input logic [7:0] t,
                           input logic [7:0] s, input int n);
    for (int b = 0; b < n; b++) begin
      ld   = 1'b1;
      sel  = 2'(lane);
      prog = t[b % 8];
      sd   = s[b % 8];
      tick();
    end
    ld = 1'b0;
    prog = 1'b0;
    sd = 1'b0;
    tick();
  endtask

  initial begin
    vec_t e;
    int   cyc;
    logic [7:0] t8, s8;

    tbl[0] = '{0, 1'b0, 8'hC0, 1'b0, 1'b0};
    tbl[1] = '{0, 1'b0, 8'hE0, 1'b0, 1'b0};
    tbl[2] = '{0, 1'b0, 8'h70, 1'b0, 1'b0};
    tbl[3] = '{2, 1'b1, 8'hB8, 1'b0, 1'b0};
    tbl[4] = '{2, 1'b1, 8'h5C, 1'b0, 1'b0};
    tbl[5] = '{2, 1'b1, 8'h2E, 1'b0, 1'b0};
    tbl[6] = '{1, 1'b0, 8'h00, 1'b0, 1'b0};
    tbl[7] = '{1, 1'b0, 8'h01, 1'b1, 1'b1};

    rst_n = 1'b0;
    {ld, prog, sd, tst, run, gal} = '0;
    sel = '0;
    #3;
    chk("rst_valid", 32'(valid), 0);
    chk("rst_lock", 32'(lock), 0);
    chk("rst_out", 32'(out), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(tdone), 0);
    #9 rst_n = 1'b1;
    tick();

    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin
        load_lane(0, 8'hB8, 8'h80, 8);
        chk("fib_load_lf0", 32'(lf[0]), 32'h80);
        chk("fib_valid", 32'(valid), 32'b0001);
        chk("fib_lane1", 32'(lf[1]), 0);
        chk("fib_lane2", 32'(lf[2]), 0);
        chk("fib_lane3", 32'(lf[3]), 0);
      end else if (i == 3) begin
        load_lane(2, 8'hB8, 8'h01, 8);
        chk("gal_out_pre", 32'(out[2]), 1);
        chk("gal_valid", 32'(valid), 32'b0101);
      end else if (i == 6) begin
        load_lane(1, 8'hB8, 8'h01, 8);
      end
      sbq.push_back(tbl[i]);
      run = 1'b1;
      gal = tbl[i].gal;
      tick();
      run = 1'b0;
      e = sbq.pop_front();
      chk($sformatf("row%0d_lfsr", i), 32'(lf[e.lane]), 32'(e.exp_lf));
      chk($sformatf("row%0d_out", i), 32'(out[e.lane]), 32'(e.exp_out));
      chk($sformatf("row%0d_lock", i), 32'(lock[e.lane]),
          32'(e.exp_lock));
    end

    load_lane(1, 8'hB8, 8'h01, 8);
    chk("reload_lock1", 32'(lock[1]), 0);
    chk("reload_valid1", 32'(valid[1]), 1);
    chk("reload_lf1", 32'(lf[1]), 32'h01);

    load_lane(3, 8'hB8, 8'h1F, 5);
    chk("short_valid3", 32'(valid[3]), 0);
    chk("short_lf3", 32'(lf[3]), 32'hF8);
    run = 1'b1;
    tick();
    tick();
    run = 1'b0;
    chk("short_hold3", 32'(lf[3]), 32'hF8);

    load_lane(0, 8'hB8, 8'hC0, 8);
    chk("flush_pre_lf0", 32'(lf[0]), 32'hC0);
    chk("flush_pre_valid0", 32'(valid[0]), 1);
    tst = 1'b1;
    sel = 2'd0;
    tick();
    tst = 1'b0;
    cyc = 0;
    while (busy && cyc < 20) begin
      chk("flush_no_early_done", 32'(tdone), 0);
      cyc++;
      tick();
    end
    chk("flush_busy_cycles", 32'(cyc), 8);
    chk("flush_done_pulse", 32'(tdone), 1);
    tick();
    chk("flush_done_low", 32'(tdone), 0);
    chk("flush_lf0", 32'(lf[0]), 0);
    chk("flush_taps0", 32'(tp[0]), 0);
    chk("flush_valid0", 32'(valid[0]), 0);

    t8 = 8'hAA;
    s8 = 8'h55;
    for (int b = 0; b < 4; b++) begin
      ld   = 1'b1;
      sel  = 2'd2;
      prog = t8[b];
      sd   = s8[b];
      if (b == 3) begin
        #2 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(valid), 0);
        chk("arst_lock", 32'(lock), 0);
        chk("arst_out", 32'(out), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_done", 32'(tdone), 0);
      end else begin
        tick();
      end
    end
    ld = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    load_lane(2, 8'hB8, 8'h01, 8);
    chk("post_rst_valid", 32'(valid), 32'b0100);
    chk("post_rst_lf2", 32'(lf[2]), 32'h01);
    run = 1'b1;
    gal = 1'b1;
    tick();
    run = 1'b0;
    chk("post_rst_gal", 32'(lf[2]), 32'hB8);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
